sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//   Shares the single-port 256x10 SRAM between two functional requesters
//   using round-robin arbitration with a valid/grant handshake, and hands
//   the SRAM pins to the BIST engine on request once in-flight traffic drains.
//   Sits between the requesters, the bist controller and the SRAM macro.
//   Drives active-low csn/wen exactly as the bist controller does.
// PARAMETERS
//   AW   8    SRAM address width
//   DW   10   SRAM data width
// PORTS
//   clock        in   1      system clock, all logic on rising edge
//   n_reset      in   1      asynchronous, active-low reset
//   req          in   2      per-requester access request
//   req_we       in   2      1=write, 0=read, per requester
//   req_addr     in   2*AW   {addr1,addr0}
//   req_wdata    in   2*DW   {wdata1,wdata0}
//   gnt          out  2      one-hot grant; access accepted when req[i]&gnt[i]
//   rvalid       out  2      read data valid for requester i
//   rdata        out  DW     read data, shared; qualified by rvalid
//   bist_req     in   1      bist engine wants exclusive SRAM access
//   bist_ack     out  1      SRAM pins owned by bist engine
//   bist_csn     in   1      bist chip select (active low)
//   bist_wen     in   1      bist write enable (active low)
//   bist_addr    in   AW     bist address
//   bist_wdata   in   DW     bist write data
//   csn          out  1      SRAM chip select, active low
//   wen          out  1      SRAM write enable, active low
//   wr_addr      out  AW     SRAM address
//   wr_data      out  DW     SRAM write data
//   rd_data      in   DW     SRAM read data (1-cycle synchronous read)
// BEHAVIOUR
//   Reset: csn=1, wen=1, wr_addr=0, wr_data=0, gnt=0, rvalid=0, rdata=0,
//     bist_ack=0, state=FUNC, rr pointer => requester 0 has priority.
//   Arbitration (FUNC only, combinational gnt): one req -> grant it; both ->
//     grant the one not served last; pointer updates only on accepted access.
//   Pipeline: accept in cycle N -> csn/wen/addr/wdata registered, on pins in
//     N+1 -> for reads rvalid[i]=1, rdata=rd_data in N+2. One access/cycle;
//     back-to-back accesses allowed; writes produce no rvalid.
//   Cycles with no accepted access drive csn=1, wen=1 (addr/data hold).
//   req_* must be held stable until granted; dropping req before gnt is legal.
//   FSM:
//     FUNC : grants enabled. bist_req=1 -> DRAIN (no grant that same cycle).
//     DRAIN: gnt=0; stage-1 and stage-2 pipeline regs empty -> BIST.
//            bist_req drops while in DRAIN -> FUNC.
//     BIST : bist_ack=1; csn/wen/wr_addr/wr_data = bist_* (combinational
//            passthrough); gnt=0, rvalid=0. bist_req=0 -> FUNC next cycle,
//            bist_ack=0 in that cycle, registered pins idle (csn=wen=1).
//   In-flight reads at bist_req always complete (rvalid still delivered).
//   Reset mid-operation: pending reads discarded, all outputs to reset values.
//   rd_data is visible to the bist engine directly; rdata only meaningful
//   with rvalid.
// TESTING
//   1 req0 write addr 0x12 data 0x155, then read 0x12 -> rvalid[0] 2 cycles
//     after read gnt, rdata=0x155; csn/wen low exactly 1 cycle each.
//   2 req=2'b11 held 6 cycles after reset -> gnt 01,10,01,10,01,10.
//   3 alternating reads req0@0x00, req1@0xFF (prewritten 0x0AA/0x3FF) ->
//     rvalid 01,10 back-to-back, rdata 0x0AA then 0x3FF.
//   4 bist_req during req1 read -> rvalid[1] delivered, gnt=0, bist_ack=1
//     once pipe empty; bist_csn=0, bist_addr=0x40 seen on csn/wr_addr same cycle.
//   5 bist_req drops with req0 pending -> bist_ack=0, gnt[0]=1 next cycle.
//   6 n_reset low 1 cycle after a read gnt -> rvalid never asserts, csn=1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: round-robin share of a single-port SRAM between two
// requesters, with a drain-then-handover path to the BIST engine.
module sram_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 10
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic [1:0]    req,
  input  logic [1:0]    req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]    gnt,
  output logic [1:0]    rvalid,
  output logic [DW-1:0] rdata,
  input  logic          bist_req,
  output logic          bist_ack,
  input  logic          bist_csn,
  input  logic          bist_wen,
  input  logic [AW-1:0] bist_addr,
  input  logic [DW-1:0] bist_wdata,
  output logic          csn,
  output logic          wen,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  input  logic [DW-1:0] rd_data
);

  typedef enum logic [1:0] {
    S_FUNC,
    S_DRAIN,
    S_BIST
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_csn;
  logic          r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_s1_rd;
  logic          r_s1_id;
  logic [1:0]    r_rvalid;

  logic [1:0]    w_gnt;
  logic          w_acc;
  logic          w_id;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_bist;

  // r_last names the requester served most recently; the other wins a tie
  always_comb begin
    w_gnt = 2'b00;
    if (r_state == S_FUNC && !bist_req) begin
      unique case (1'b1)
        req[0] && (!req[1] || r_last): w_gnt = 2'b01;
        req[1] && (!req[0] || !r_last): w_gnt = 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_acc   = |(req & w_gnt);
  assign w_id    = w_gnt[1];
  assign w_we    = w_id ? req_we[1] : req_we[0];
  assign w_addr  = w_id ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign w_wdata = w_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= S_FUNC;
      r_last   <= 1'b1;
      r_csn    <= 1'b1;
      r_wen    <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_s1_rd  <= 1'b0;
      r_s1_id  <= 1'b0;
      r_rvalid <= 2'b00;
    end else begin
      r_csn   <= 1'b1;
      r_wen   <= 1'b1;
      r_s1_rd <= 1'b0;
      if (w_acc) begin
        r_csn   <= 1'b0;
        r_wen   <= ~w_we;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
        r_s1_rd <= ~w_we;
        r_s1_id <= w_id;
        r_last  <= w_id;
      end
      if (r_s1_rd)
        r_rvalid <= r_s1_id ? 2'b10 : 2'b01;
      else
        r_rvalid <= 2'b00;
      // stage 1 busy shows as a low r_csn; stage 2 as any rvalid
      unique case (r_state)
        S_FUNC: begin
          if (bist_req) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!bist_req)
            r_state <= S_FUNC;
          else if (r_csn && r_rvalid == 2'b00)
            r_state <= S_BIST;
        end
        S_BIST: begin
          if (!bist_req) r_state <= S_FUNC;
        end
        default: r_state <= S_FUNC;
      endcase
    end
  end

  assign w_bist   = (r_state == S_BIST);
  assign bist_ack = w_bist;
  assign gnt      = w_gnt;
  assign rvalid   = r_rvalid;
  assign rdata    = (|r_rvalid) ? rd_data : '0;
  assign csn      = w_bist ? bist_csn : r_csn;
  assign wen      = w_bist ? bist_wen : r_wen;
  assign wr_addr  = w_bist ? bist_addr : r_addr;
  assign wr_data  = w_bist ? bist_wdata : r_wdata;

endmodule
